ftoi_pipe: RTL and testbench
============================

Name: ftoi_pipe

Overview:
- Pipelined IEEE-754 single-precision to signed 32-bit integer converter; the inverse of the int-to-float IP model.
- Used where shader/raytracer results (float) must become integer pixel coordinates, indices or colour components.
- Accepts one operand per cycle and produces results after a fixed latency.
- Drop-in timing-compatible with the int-to-float unit: same `en` gating semantics and the same default 4-cycle latency.

Parameters:
- LATENCY, 4, pipeline depth in cycles from input to `q`; legal range 3..8. Stages beyond 3 are pure delay registers appended at the output.

Ports:
- clk  input  1  clock; all logic on the rising edge
- areset  input  1  reset, synchronous, active-high
- en  input  1  unit enable; low flushes the pipeline and forces `q` to 0
- in_valid  input  1  `a` carries a valid operand this cycle
- a  input  32  IEEE-754 single-precision operand
- out_valid  output  1  `q`/flags hold the result of an operand accepted LATENCY cycles earlier
- q  output  32  signed two's-complement result
- invalid  output  1  result came from a NaN input
- overflow  output  1  result saturated (±Inf or magnitude out of range)

Behaviour:
- Reset: on a rising edge with `areset`=1, every pipeline register, including the valid bits, is cleared. `q`=0, `out_valid`=0, `invalid`=0, `overflow`=0 from the next cycle. This takes priority over `en`.
- Operand acceptance: an operand is accepted when `en`=1 and `in_valid`=1. No backpressure; every accepted operand appears exactly LATENCY cycles later.
- `en`=0: all stage registers and valid bits load 0 on that edge. Outputs are combinationally gated: `q`, `out_valid`, `invalid` and `overflow` are 0 while `en`=0. When `en` returns, the first result appears LATENCY cycles after the first accepted operand.
- Bubbles: `in_valid`=0 with `en`=1 advances a bubble. A bubble outputs `q`=0 with all flags 0.
- Stage 1: unpack sign s, exponent e=a[30:23], mantissa m={1,a[22:0]}, then classify:
  - zero/denormal (e=0)
  - small (1≤e≤126)
  - normal (127≤e≤157)
  - boundary (e=158)
  - large (159≤e≤254)
  - Inf (e=255, frac=0)
  - NaN (e=255, frac≠0)
- Stage 2: magnitude alignment. For normal, shift m left by (e-150) when e≥150, else right by (150-e), keeping guard and sticky bits. Width is 32 bits of magnitude plus guard plus sticky.
- Stage 3: rounding, negation when s=1, and saturation. This is the final stage when LATENCY=3.
- Rounding: truncation toward zero (default, see Optional Feature).
- Special cases:
  - zero/denormal/small → 0, no flags. -0.0 → 0.
  - NaN → q=0, invalid=1.
  - +Inf and positive large/boundary → 0x7FFFFFFF, overflow=1.
  - -Inf and negative large → 0x80000000, overflow=1.
  - Negative boundary with frac=0 (exactly -2^31, 0xCF000000) → 0x80000000, no flag. Negative boundary with frac≠0 → saturate, overflow=1.
  - A rounding result that exceeds range saturates and sets overflow.
- Flags travel with their result and are mutually exclusive.

Optional Feature:
- Macro: FTOI_ROUND_NEAREST_EN.
- Defined: round to nearest, ties to even, using the guard bit, the sticky bit and the LSB. Small inputs (1≤e≤126) round to 0 or ±1 accordingly, e.g. 0.5→0, 0.75→1. Rounding never changes latency.
- Undefined: truncate toward zero. The rounding logic is absent and guard/sticky are dropped.

Test Plan:
- Latency and basic values: a=0x3F800000 (1.0), in_valid=1, LATENCY=4 → out_valid=1 and q=0x00000001 exactly 4 cycles later. a=0xC0200000 (-2.5) → q=0xFFFFFFFE in both modes.
- Rounding mode: a=0x3FC00000 (1.5) → q=1 truncating, q=2 with FTOI_ROUND_NEAREST_EN. a=0x40200000 (2.5) → q=2 in both modes.
- Range limits:
  - 0x4F000000 (2^31) → 0x7FFFFFFF, overflow=1.
  - 0xCF000000 → 0x80000000, overflow=0.
  - 0xFF800000 (-Inf) → 0x80000000, overflow=1.
  - 0x7FC00000 (NaN) → 0, invalid=1.
  - 0x80000000 (-0) and 0x00000001 (denormal) → 0, no flags.
- Streaming with bubbles: 8 back-to-back operands 1.0..8.0, with a bubble after 4.0 → outputs 1..4, then one cycle of out_valid=0, then 5..8, in order, on consecutive cycles.
- `en` drop mid-stream: deassert `en` for 1 cycle while 3 operands are in flight → q=0 and out_valid=0 during that cycle. The in-flight results never appear. The next accepted operand appears LATENCY cycles after acceptance.
- Reset mid-operation: assert `areset` for 1 cycle with the pipeline full → all outputs 0 from the next edge. No stale result emerges in the following LATENCY cycles.

Source files
------------

// File: rtl/ftoi_pipe.sv
// Pipelined IEEE-754 single -> signed int32 converter, fixed LATENCY (3..8).
// Default truncates toward zero; define FTOI_ROUND_NEAREST_EN for round-to-nearest-even.
module ftoi_pipe #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        en,
  input  logic        in_valid,
  input  logic [31:0] a,
  output logic        out_valid,
  output logic [31:0] q,
  output logic        invalid,
  output logic        overflow
);

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SMALL,
    CLS_NORM,
    CLS_BOUND,
    CLS_LARGE,
    CLS_INF,
    CLS_NAN
  } cls_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] q;
    logic        invalid;
    logic        overflow;
  } res_t;

  localparam int unsigned NDLY = LATENCY - 3;

  // ---------------- stage 1: unpack and classify ----------------
  cls_t        cls_d;
  logic        s1_valid;
  logic        s1_sign;
  cls_t        s1_cls;
  logic [7:0]  s1_exp;
  logic [23:0] s1_man;

  always_comb begin
    cls_d = CLS_ZERO;
    if (a[30:23] == 8'd0)             cls_d = CLS_ZERO;
    else if (a[30:23] <= 8'd126)      cls_d = CLS_SMALL;
    else if (a[30:23] <= 8'd157)      cls_d = CLS_NORM;
    else if (a[30:23] == 8'd158)      cls_d = CLS_BOUND;
    else if (a[30:23] <= 8'd254)      cls_d = CLS_LARGE;
    else if (a[22:0] == 23'd0)        cls_d = CLS_INF;
    else                              cls_d = CLS_NAN;
  end

  // Bubbles load all-zero fields so they flow through as a clean zero result.
  always_ff @(posedge clk) begin
    if (areset || !en) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_exp   <= '0;
      s1_man   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_sign  <= in_valid & a[31];
      s1_cls   <= in_valid ? cls_d : CLS_ZERO;
      s1_exp   <= in_valid ? a[30:23] : 8'd0;
      s1_man   <= in_valid ? {1'b1, a[22:0]} : 24'd0;
    end
  end

  // ---------------- stage 2: magnitude alignment ----------------
  logic [3:0]  lsh;
  logic [4:0]  rsh;
  logic [31:0] mag_d;
  logic        s2_valid;
  logic        s2_sign;
  cls_t        s2_cls;
  logic [31:0] s2_mag;
`ifdef FTOI_ROUND_NEAREST_EN
  logic [23:0] below;
  logic        guard_d;
  logic        sticky_d;
  logic        s2_guard;
  logic        s2_sticky;
`endif

  // Boundary (e=158) shares the normal shifter: its 32-bit magnitude is
  // resolved by the saturation check, which yields exact -2^31 for free.
  always_comb begin
    mag_d = '0;
    lsh   = 4'(s1_exp - 8'd150);
    rsh   = 5'(8'd150 - s1_exp);
`ifdef FTOI_ROUND_NEAREST_EN
    below    = ~(24'hFF_FFFF << rsh);
    guard_d  = 1'b0;
    sticky_d = 1'b0;
`endif
    if (s1_cls == CLS_NORM || s1_cls == CLS_BOUND) begin
      if (s1_exp >= 8'd150) begin
        mag_d = {8'd0, s1_man} << lsh;
      end else begin
        mag_d = {8'd0, s1_man >> rsh};
`ifdef FTOI_ROUND_NEAREST_EN
        guard_d  = |(s1_man & (below ^ (below >> 1)));
        sticky_d = |(s1_man & (below >> 1));
`endif
      end
    end
`ifdef FTOI_ROUND_NEAREST_EN
    else if (s1_cls == CLS_SMALL) begin
      // Value below 1: guard is the 0.5 weight, sticky anything under it.
      guard_d  = (s1_exp == 8'd126);
      sticky_d = (s1_exp != 8'd126) || (s1_man[22:0] != 23'd0);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (areset || !en) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_cls    <= CLS_ZERO;
      s2_mag    <= '0;
`ifdef FTOI_ROUND_NEAREST_EN
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
`endif
    end else begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_cls    <= s1_cls;
      s2_mag    <= mag_d;
`ifdef FTOI_ROUND_NEAREST_EN
      s2_guard  <= guard_d;
      s2_sticky <= sticky_d;
`endif
    end
  end

  // ---------------- stage 3: round, negate, saturate ----------------
  logic [32:0] rmag;
  logic [31:0] sat_val;
  res_t        res_d;

  always_comb begin
`ifdef FTOI_ROUND_NEAREST_EN
    rmag = {1'b0, s2_mag} + 33'(s2_guard & (s2_sticky | s2_mag[0]));
`else
    rmag = {1'b0, s2_mag};
`endif
    sat_val = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    res_d   = '0;
    case (s2_cls)
      CLS_NAN: res_d.invalid = 1'b1;
      CLS_LARGE, CLS_INF: begin
        res_d.q        = sat_val;
        res_d.overflow = 1'b1;
      end
      default: begin
        if (s2_sign) begin
          if (rmag > 33'h0_8000_0000) begin
            res_d.q        = sat_val;
            res_d.overflow = 1'b1;
          end else begin
            res_d.q = -rmag[31:0];
          end
        end else begin
          if (rmag > 33'h0_7FFF_FFFF) begin
            res_d.q        = sat_val;
            res_d.overflow = 1'b1;
          end else begin
            res_d.q = rmag[31:0];
          end
        end
      end
    endcase
    if (!s2_valid) res_d = '0;
    res_d.valid = s2_valid;
  end

  // ---------------- result register plus output delay line ----------------
  res_t pipe [0:NDLY];

  always_ff @(posedge clk) begin
    if (areset || !en) pipe[0] <= '0;
    else               pipe[0] <= res_d;
  end

  for (genvar g = 1; g <= NDLY; g++) begin : g_dly
    always_ff @(posedge clk) begin
      if (areset || !en) pipe[g] <= '0;
      else               pipe[g] <= pipe[g-1];
    end
  end

  always_comb begin
    out_valid = en & pipe[NDLY].valid;
    q         = en ? pipe[NDLY].q : 32'd0;
    invalid   = en & pipe[NDLY].invalid;
    overflow  = en & pipe[NDLY].overflow;
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Self-checking bench for ftoi_pipe: vector table streamed through a timed
// scoreboard, plus hand sequences for bubbles, en drop and mid-stream reset.
module tb_ftoi_pipe;

  localparam int unsigned LAT = 4;
`ifdef FTOI_ROUND_NEAREST_EN
  localparam bit RN = 1'b1;
`else
  localparam bit RN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic        out_valid;
  logic [31:0] q;
  logic        invalid;
  logic        overflow;

  always #5 clk = ~clk;

  ftoi_pipe #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .areset    (areset),
    .en        (en),
    .in_valid  (in_valid),
    .a         (a),
    .out_valid (out_valid),
    .q         (q),
    .invalid   (invalid),
    .overflow  (overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] q;
    logic        inv;
    logic        ovf;
    string       nm;
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [31:0] q;
    logic        inv;
    logic        ovf;
    string       nm;
  } exp_t;

  vec_t        vt[$];
  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic add(input logic [31:0] av, input logic [31:0] qv,
                     input logic iv, input logic ov, input string nm);
    vec_t v;
    v.a = av; v.q = qv; v.inv = iv; v.ovf = ov; v.nm = nm;
    vt.push_back(v);
  endtask

  // Drive one cycle, advance the model, then check outputs #1 after the edge.
  task automatic tick(input logic e, input logic v, input logic r,
                      input logic [31:0] av, input logic [31:0] eq,
                      input logic ei, input logic eo, input string nm);
    exp_t        x;
    logic        wv;
    logic [31:0] wq;
    logic        wi, wo;
    string       cn;
    en = e; in_valid = v; areset = r; a = av;
    if (r || !e) begin
      sb.delete();
    end else if (v) begin
      x.due = cyc + LAT; x.q = eq; x.inv = ei; x.ovf = eo; x.nm = nm;
      sb.push_back(x);
    end
    @(posedge clk);
    cyc++;
    #1;
    wv = 1'b0; wq = '0; wi = 1'b0; wo = 1'b0; cn = r ? "reset" : (e ? "idle" : "en_low");
    if (sb.size() != 0 && sb[0].due == cyc) begin
      x = sb.pop_front();
      wv = 1'b1; wq = x.q; wi = x.inv; wo = x.ovf; cn = x.nm;
    end
    n_cmp++;
    if ({out_valid, q, invalid, overflow} !== {wv, wq, wi, wo}) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got v=%0b q=%08h inv=%0b ovf=%0b, want v=%0b q=%08h inv=%0b ovf=%0b",
               cn, cyc, out_valid, q, invalid, overflow, wv, wq, wi, wo);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "");
  endtask

  task automatic push(input logic [31:0] av, input logic [31:0] eq, input string nm);
    tick(1'b1, 1'b1, 1'b0, av, eq, 1'b0, 1'b0, nm);
  endtask

  initial begin
    add(32'h3F80_0000, 32'h0000_0001,             1'b0, 1'b0, "one");
    add(32'hC020_0000, 32'hFFFF_FFFE,             1'b0, 1'b0, "neg2p5");
    add(32'h3FC0_0000, RN ? 32'd2 : 32'd1,        1'b0, 1'b0, "1p5");
    add(32'h4020_0000, 32'd2,                     1'b0, 1'b0, "2p5");
    add(32'h4060_0000, RN ? 32'd4 : 32'd3,        1'b0, 1'b0, "3p5");
    add(32'h4F00_0000, 32'h7FFF_FFFF,             1'b0, 1'b1, "pos2p31");
    add(32'hCF00_0000, 32'h8000_0000,             1'b0, 1'b0, "neg2p31");
    add(32'hCF00_0001, 32'h8000_0000,             1'b0, 1'b1, "negbound_frac");
    add(32'hFF80_0000, 32'h8000_0000,             1'b0, 1'b1, "neg_inf");
    add(32'h7F80_0000, 32'h7FFF_FFFF,             1'b0, 1'b1, "pos_inf");
    add(32'h7FC0_0000, 32'h0,                     1'b1, 1'b0, "nan");
    add(32'hFFC0_0001, 32'h0,                     1'b1, 1'b0, "neg_nan");
    add(32'h8000_0000, 32'h0,                     1'b0, 1'b0, "neg_zero");
    add(32'h0000_0001, 32'h0,                     1'b0, 1'b0, "denorm");
    add(32'h0080_0000, 32'h0,                     1'b0, 1'b0, "min_normal");
    add(32'h3E80_0000, 32'h0,                     1'b0, 1'b0, "0p25");
    add(32'h3F00_0000, 32'h0,                     1'b0, 1'b0, "0p5");
    add(32'h3F40_0000, RN ? 32'd1 : 32'd0,        1'b0, 1'b0, "0p75");
    add(32'hBF40_0000, RN ? 32'hFFFF_FFFF : 32'd0, 1'b0, 1'b0, "neg0p75");
    add(32'h3FFF_FFFF, RN ? 32'd2 : 32'd1,        1'b0, 1'b0, "almost2");
    add(32'hC2F7_0000, RN ? 32'hFFFF_FF84 : 32'hFFFF_FF85, 1'b0, 1'b0, "neg123p5");
    add(32'h4AFF_FFFF, RN ? 32'd8388608 : 32'd8388607, 1'b0, 1'b0, "e149_tie");
    add(32'h4B00_0001, 32'd8388609,               1'b0, 1'b0, "e150");
    add(32'h4B7F_FFFF, 32'h00FF_FFFF,             1'b0, 1'b0, "e150_max");
    add(32'h4EFF_FFFF, 32'h7FFF_FF80,             1'b0, 1'b0, "e157_max");
    add(32'h5F00_0000, 32'h7FFF_FFFF,             1'b0, 1'b1, "pos_large");
    add(32'hDF00_0000, 32'h8000_0000,             1'b0, 1'b1, "neg_large");
    add(32'h7F7F_FFFF, 32'h7FFF_FFFF,             1'b0, 1'b1, "max_finite");
    add(32'hC000_0000, 32'hFFFF_FFFE,             1'b0, 1'b0, "neg2");

    // Reset state
    tick(1'b1, 1'b1, 1'b1, 32'h3F80_0000, 32'h0, 1'b0, 1'b0, "");
    tick(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, "");
    idle(2);

    // Single operand: result must appear exactly LAT cycles later, zeros around it
    push(32'h3F80_0000, 32'd1, "latency_one");
    idle(LAT + 2);

    // Table streamed back-to-back
    for (int unsigned i = 0; i < vt.size(); i++)
      tick(1'b1, 1'b1, 1'b0, vt[i].a, vt[i].q, vt[i].inv, vt[i].ovf, vt[i].nm);
    idle(LAT + 2);

    // Streaming 1.0..8.0 with a bubble after 4.0
    push(32'h3F80_0000, 32'd1, "s1");
    push(32'h4000_0000, 32'd2, "s2");
    push(32'h4040_0000, 32'd3, "s3");
    push(32'h4080_0000, 32'd4, "s4");
    idle(1);
    push(32'h40A0_0000, 32'd5, "s5");
    push(32'h40C0_0000, 32'd6, "s6");
    push(32'h40E0_0000, 32'd7, "s7");
    push(32'h4100_0000, 32'd8, "s8");
    idle(LAT + 2);

    // en drop for one cycle with three operands in flight
    push(32'h4120_0000, 32'd10, "fl_a");
    push(32'h4130_0000, 32'd11, "fl_b");
    push(32'h4140_0000, 32'd12, "fl_c");
    tick(1'b0, 1'b1, 1'b0, 32'h4150_0000, 32'd13, 1'b0, 1'b0, "");
    push(32'h4160_0000, 32'd14, "after_en");
    idle(LAT + 2);

    // Reset with the pipeline full: nothing stale may emerge
    push(32'hC080_0000, 32'hFFFF_FFFC, "rs_a");
    push(32'h4F00_0000, 32'h7FFF_FFFF, "rs_b");
    push(32'h7FC0_0000, 32'h0, "rs_c");
    push(32'h40A0_0000, 32'd5, "rs_d");
    tick(1'b1, 1'b1, 1'b1, 32'h40C0_0000, 32'd6, 1'b0, 1'b0, "");
    idle(LAT + 2);

    // Post-reset operand still flows normally
    push(32'hC120_0000, 32'hFFFF_FFF6, "post_reset");
    idle(LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
